ring_osc_meter: RTL and testbench
=================================

// Module: ring_osc_meter
// PURPOSE
//  Sequencer/measurement controller for the enable-gated ring oscillator.
//  On a start request it enables the ring, waits a settle interval, counts
//  synchronized rising edges of the ring output over a fixed window of
//  system clocks, then disables the ring and reports the count.
//  Sits between control logic (start/abort) and one ring oscillator instance
//  (drives its en, samples its clk_out).
// PARAMETERS
//  WINDOW_CYCLES  1024  measurement window length in clk cycles (>=1)
//  SETTLE_CYCLES  4     cycles ring runs before counting starts (>=1)
//  CNT_W          16    width of edge counter / count output
//  SYNC_STAGES    2     flip-flop stages synchronizing ring_clk into clk (>=2)
// PORTS
//  clk       in   1      system clock, all logic on rising edge
//  rst       in   1      synchronous reset, active high
//  start     in   1      request a measurement; sampled only in IDLE
//  abort     in   1      cancel a measurement in progress
//  ring_clk  in   1      ring oscillator clk_out (asynchronous to clk)
//  ring_en   out  1      registered enable to ring oscillator en
//  busy      out  1      high in any state other than IDLE
//  done      out  1      one-cycle pulse: count/overflow valid
//  count     out  CNT_W  rising edges seen in the window (saturating)
//  overflow  out  1      sticky: count saturated during this measurement
// BEHAVIOUR
//  - Reset: state=IDLE; ring_en=0, busy=0, done=0, count=0, overflow=0;
//    synchronizer and edge-detect flops cleared to 0. Reset wins over all inputs.
//  - ring_clk passes through SYNC_STAGES flops, then one more flop for edge
//    detect; edge = sync_out & ~prev. No logic uses ring_clk directly.
//  - FSM (all outputs registered):
//    IDLE:    start & ~abort at edge E0 -> SETTLE; clear count/overflow,
//             ring_en=1 and busy=1 from E0.
//    SETTLE:  SETTLE_CYCLES cycles; edges ignored -> MEASURE.
//    MEASURE: exactly WINDOW_CYCLES cycles; count += 1 for every cycle with
//             edge=1. At CNT_W max, count holds and overflow sets.
//             Exit -> DRAIN; ring_en=0 from that edge (E0+SETTLE+WINDOW).
//    DRAIN:   SYNC_STAGES+1 cycles; edges NOT counted; synchronizer flushed.
//             -> DONE.
//    DONE:    done=1 for exactly one cycle, rising at edge
//             E0+SETTLE_CYCLES+WINDOW_CYCLES+SYNC_STAGES+1 -> IDLE.
//  - busy = (state != IDLE), so busy is still high during the DONE cycle.
//  - count and overflow hold their final values in IDLE until the next
//    accepted start.
//  - start outside IDLE is ignored; start held high in IDLE after DONE
//    begins a new measurement on the first IDLE cycle.
//  - abort in SETTLE/MEASURE/DRAIN -> IDLE on next edge; ring_en=0, busy=0,
//    count=0, overflow=0, no done. abort in DONE: done still pulses, then IDLE.
//    abort in IDLE blocks start.
//  - The edge counter is not reset by window boundaries other than an
//    accepted start or an abort.
// TESTING
//  1 Reset: assert rst 3 cycles with start=1 and ring_clk toggling
//    -> ring_en=busy=done=count=overflow=0 throughout.
//  2 Nominal: WINDOW=64, SETTLE=4, SYNC=2, ring_clk period 8 clk, start at E0
//    -> ring_en=1 E0..E67, done pulse at E71 only, count=8, overflow=0.
//  3 Saturation: CNT_W=3, ring_clk period 2 clk, WINDOW=64
//    -> count=7, overflow=1 at done; next start clears both.
//  4 Abort: nominal setup, abort at E30 (MEASURE)
//    -> ring_en=0, busy=0 after E30; count=0; no done ever pulses.
//  5 Handshake: start pulsed at E10 while busy -> ignored, one done only;
//    start=abort=1 in IDLE -> stays IDLE.
//  6 Dead ring: ring_clk tied 0 -> done at E71, count=0, overflow=0.

Source files
------------

// File: rtl/ring_osc_meter.sv
// ring_osc_meter
//   Sequencer and measurement controller for an enable-gated ring oscillator.
//   On an accepted start it enables the ring and lets it settle. It then counts
//   synchronized rising edges of the ring output over a fixed window of system
//   clocks. Finally it disables the ring, drains the synchronizer and reports
//   the count with a one-cycle done pulse.
//
// Ports
//   clk       in   system clock, all logic on its rising edge
//   rst       in   synchronous reset, active high
//   start     in   measurement request, honoured only in IDLE (and not with abort)
//   abort     in   cancel a measurement in SETTLE/MEASURE/DRAIN; blocks start in IDLE
//   ring_clk  in   ring oscillator output, asynchronous to clk
//   ring_en   out  registered enable to the ring oscillator
//   busy      out  high whenever the controller is not IDLE (including DONE)
//   done      out  one-cycle pulse, count/overflow valid
//   count     out  rising ring edges seen in the window, saturating at all-ones
//   overflow  out  sticky: an edge arrived while count was already saturated
module ring_osc_meter #(
    parameter int WINDOW_CYCLES = 1024,
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 16,
    parameter int SYNC_STAGES   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             ring_clk,
    output logic             ring_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETTLE  = 3'd1;
    localparam logic [2:0] ST_MEASURE = 3'd2;
    localparam logic [2:0] ST_DRAIN   = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    // One down-counter times every phase, so it must hold the longest load.
    localparam int TMAX_SW = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES : SETTLE_CYCLES;
    localparam int TMAX    = (TMAX_SW > SYNC_STAGES) ? TMAX_SW : SYNC_STAGES;
    localparam int TIMER_W = $clog2(TMAX + 1);

    // Each phase loads length-1 and leaves when the timer reads zero.
    // DRAIN lasts SYNC_STAGES+1 cycles, so it loads SYNC_STAGES.
    localparam logic [TIMER_W-1:0] SETTLE_LOAD = TIMER_W'(SETTLE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] WINDOW_LOAD = TIMER_W'(WINDOW_CYCLES - 1);
    localparam logic [TIMER_W-1:0] DRAIN_LOAD  = TIMER_W'(SYNC_STAGES);
    localparam logic [CNT_W-1:0]   CNT_MAX     = {CNT_W{1'b1}};

    logic [2:0]             state_q,    state_d;
    logic [TIMER_W-1:0]     timer_q,    timer_d;
    logic [CNT_W-1:0]       count_q,    count_d;
    logic                   overflow_q, overflow_d;
    logic                   ring_en_q,  ring_en_d;
    logic                   busy_q,     busy_d;
    logic                   done_q,     done_d;
    logic [SYNC_STAGES-1:0] sync_q,     sync_d;
    logic                   prev_q,     prev_d;
    logic                   ring_edge;
    logic                   in_run;

    // Synchronizer chain plus one extra flop for rising-edge detection.
    // ring_clk feeds only the first synchronizer stage.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], ring_clk};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    assign ring_edge = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign in_run    = (state_q == ST_SETTLE) || (state_q == ST_MEASURE) ||
                       (state_q == ST_DRAIN);

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        ring_en_d  = ring_en_q;

        if (abort && in_run) begin
            // Cancelled measurement: nothing is reported, results are cleared.
            state_d    = ST_IDLE;
            timer_d    = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            ring_en_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && !abort) begin
                        state_d    = ST_SETTLE;
                        timer_d    = SETTLE_LOAD;
                        count_d    = '0;
                        overflow_d = 1'b0;
                        ring_en_d  = 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (timer_q == '0) begin
                        state_d = ST_MEASURE;
                        timer_d = WINDOW_LOAD;
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
                ST_MEASURE: begin
                    if (ring_edge) begin
                        if (count_q == CNT_MAX) begin
                            overflow_d = 1'b1;
                        end else begin
                            count_d = count_q + 1'b1;
                        end
                    end
                    if (timer_q == '0) begin
                        state_d   = ST_DRAIN;
                        timer_d   = DRAIN_LOAD;
                        ring_en_d = 1'b0;
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // Edges still emerging from the synchronizer are discarded.
                    if (timer_q == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
                ST_DONE: begin
                    // An abort arriving here is moot: the result is already out.
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d   = ST_IDLE;
                    ring_en_d = 1'b0;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            ring_en_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sync_q     <= '0;
            prev_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            ring_en_q  <= ring_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            sync_q     <= sync_d;
            prev_q     <= prev_d;
        end
    end

    assign ring_en  = ring_en_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_ring_osc_meter.sv
// Testbench for ring_osc_meter. A free-running synthetic ring clock is
// defined as a function of the clk cycle number. A reference model counts the
// rising edges of that waveform that fall in the measurement window. Each
// accepted start pushes its expected result and done cycle onto a queue, and
// a monitor pops and compares on every done pulse.
module tb_ring_osc_meter;

    localparam int W     = 64;
    localparam int S     = 4;
    localparam int SYNC  = 2;
    localparam int CW    = 5;
    localparam int CMAX  = (1 << CW) - 1;
    localparam int RUN   = S + W + SYNC + 1;   // E0 to done-edge distance

    typedef struct {
        int cnt;
        bit ovf;
        int done_cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic          ring_clk;
    logic          ring_en;
    logic          busy;
    logic          done;
    logic [CW-1:0] count;
    logic          overflow;

    int   cyc = 0;
    int   ring_period = 0;
    int   ring_phase  = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_txn    = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    ring_osc_meter #(
        .WINDOW_CYCLES(W),
        .SETTLE_CYCLES(S),
        .CNT_W        (CW),
        .SYNC_STAGES  (SYNC)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .abort   (abort),
        .ring_clk(ring_clk),
        .ring_en (ring_en),
        .busy    (busy),
        .done    (done),
        .count   (count),
        .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Ring waveform as seen at posedge k: high for the first half of each period.
    function automatic logic ring_val(input int k);
        if (ring_period == 0) return 1'b0;
        return ((k + ring_phase) % ring_period) < (ring_period / 2);
    endfunction

    // Ring value is changed on the falling edge, ready for the next posedge.
    always @(negedge clk) ring_clk = ring_val(cyc + 1);

    // A ring rise first seen at posedge j is counted at posedge j+SYNC. Only
    // counting edges E0+S+1 .. E0+S+W belong to the window.
    function automatic void model(input int e0, output int c, output bit o);
        int raw = 0;
        for (int j = e0 + S + 1 - SYNC; j <= e0 + S + W - SYNC; j++) begin
            if (ring_val(j) && !ring_val(j - 1)) raw++;
        end
        o = (raw > CMAX);
        c = o ? CMAX : raw;
    endfunction

    task automatic check(input bit ok, input string name, input int act, input int req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                check(1'b0, "unexpected_done", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                n_txn++;
                $display("txn %0d: count=%0d overflow=%0d done at cycle %0d",
                         n_txn, count, overflow, cyc);
                check(cyc == mon_e.done_cyc, "done_cycle", cyc, mon_e.done_cyc);
                check(int'(count) == mon_e.cnt, "count", int'(count), mon_e.cnt);
                check(overflow == mon_e.ovf, "overflow", int'(overflow), int'(mon_e.ovf));
            end
        end
    end

    // Called at the negedge before E0 with start already high. a>0 asserts
    // abort so that it is sampled at edge E0+a. poke pulses start at E0+10.
    // keep leaves start high throughout.
    task automatic launch(input int e0, input int a, input bit poke, input bit keep);
        exp_t e;
        int   dend;
        bit   aborted;
        bit   active;
        dend    = e0 + RUN;
        aborted = (a > 0) && (a <= RUN);
        model(e0, e.cnt, e.ovf);
        e.done_cyc = dend;
        if (!aborted) exp_q.push_back(e);
        for (int n = e0; n <= dend + 1; n++) begin
            @(negedge clk);
            active = (n >= e0) && (n <= dend) && !(aborted && n >= e0 + a);
            check(busy == active, "busy", int'(busy), int'(active));
            check(ring_en == (active && n < e0 + S + W), "ring_en",
                  int'(ring_en), int'(active && n < e0 + S + W));
            if (n == e0) begin
                check(count == '0, "count_cleared", int'(count), 0);
                check(overflow == 1'b0, "overflow_cleared", int'(overflow), 0);
            end
            if (aborted && n >= e0 + a)
                check(count == '0, "abort_count", int'(count), 0);
            if (!aborted && n == dend + 1)
                check(int'(count) == e.cnt, "count_hold", int'(count), e.cnt);
            start = keep || (poke && n == e0 + 9);
            abort = (a > 0) && (n == e0 + a - 1);
        end
        abort = 1'b0;
    endtask

    task automatic measure(input int per, input int ph, input int a, input bit poke);
        int e0;
        @(negedge clk);
        ring_period = per;
        ring_phase  = ph;
        repeat (3) @(negedge clk);
        start = 1'b1;
        e0 = cyc + 1;
        launch(e0, a, poke, 1'b0);
        start = 1'b0;
    endtask

    initial begin
        int e0;
        int per;
        int ph;
        int a;
        bit poke;

        rst   = 1'b1;
        start = 1'b1;
        abort = 1'b0;
        ring_period = 2;

        // Reset dominates start and a toggling ring.
        repeat (3) begin
            @(negedge clk);
            check(ring_en == 1'b0, "rst_ring_en", int'(ring_en), 0);
            check(busy == 1'b0, "rst_busy", int'(busy), 0);
            check(done == 1'b0, "rst_done", int'(done), 0);
            check(count == '0, "rst_count", int'(count), 0);
            check(overflow == 1'b0, "rst_overflow", int'(overflow), 0);
        end
        rst   = 1'b0;
        start = 1'b0;

        // Nominal: period 8 over a 64-cycle window gives exactly 8 edges.
        measure(8, 3, 0, 1'b0);
        check(count == 5'd8, "nominal_count", int'(count), 8);

        // Saturation, then a fresh start clears count and overflow.
        measure(2, 0, 0, 1'b0);
        check(count == 5'd31, "sat_count", int'(count), 31);
        check(overflow == 1'b1, "sat_overflow", int'(overflow), 1);
        measure(8, 0, 0, 1'b0);
        check(overflow == 1'b0, "post_sat_overflow", int'(overflow), 0);

        // Abort in MEASURE, in SETTLE and in DRAIN.
        measure(8, 1, 30, 1'b0);
        measure(8, 1, 2, 1'b0);
        measure(8, 1, RUN, 1'b0);

        // Abort during DONE still reports.
        measure(6, 2, RUN + 1, 1'b0);

        // start while busy is ignored.
        measure(8, 5, 0, 1'b1);

        // start together with abort in IDLE does nothing.
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check(busy == 1'b0, "start_abort_busy", int'(busy), 0);
            check(ring_en == 1'b0, "start_abort_ring_en", int'(ring_en), 0);
        end
        start = 1'b0;
        abort = 1'b0;

        // Dead ring.
        measure(0, 0, 0, 1'b0);
        check(count == '0, "dead_count", int'(count), 0);

        // start held high: the next run begins on the first IDLE cycle.
        @(negedge clk);
        ring_period = 4;
        ring_phase  = 1;
        repeat (3) @(negedge clk);
        start = 1'b1;
        e0 = cyc + 1;
        launch(e0, 0, 1'b0, 1'b1);
        launch(e0 + RUN + 2, 0, 1'b0, 1'b0);
        start = 1'b0;

        // Randomized runs.
        for (int r = 0; r < 12; r++) begin
            per  = $urandom_range(12, 2);
            ph   = $urandom_range(11, 0);
            a    = ($urandom_range(3, 0) == 0) ? $urandom_range(RUN, 1) : 0;
            poke = 1'($urandom_range(1, 0));
            measure(per, ph, a, poke);
        end

        repeat (5) @(negedge clk);
        check(exp_q.size() == 0, "pending_results", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
